// File: rtl/adres_config_loader.sv
// Serial configuration loader for a daisy-chained ADRES PE scan chain.
// Streams 32-bit words LSB-first into the chain and captures the previous contents it pushes out.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_FETCH | word_ready high, chain frozen until a word arrives
//   S_SHIFT | one chain bit per cycle from the word shift register
//   S_DONE  | one-cycle done pulse, final partial readback emitted
module adres_config_loader #(
   parameter int CHAIN_LEN = 46,
   parameter int NUM_PE    = 4
) (
   input  logic        Config_Clock,
   input  logic        Config_Reset,
   input  logic        start,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        cfg_data,
   output logic        cfg_shift_en,
   input  logic        cfg_return,
   output logic [31:0] rb_word,
   output logic        rb_valid,
   output logic        busy,
   output logic        done
);

   localparam int TOTAL  = CHAIN_LEN * NUM_PE;
   localparam int NWORDS = (TOTAL + 31) / 32;
   localparam int CW     = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] bit_cnt_q;
   logic [4:0]    widx_q;
   logic [30:0]   shreg_q;
   logic [31:0]   rb_acc_q;
   logic [31:0]   rb_acc_d;
   logic [31:0]   rb_word_q;
   logic          rb_valid_q;
   logic          word_ready_q;
   logic          cfg_data_q;
   logic          shift_en_q;
   logic          busy_q;
   logic          done_q;

   // Returned bit lands at the word bit index, so a short final word stays zero-extended.
   always_comb begin
      rb_acc_d         = rb_acc_q;
      rb_acc_d[widx_q] = cfg_return;
   end

   always_ff @(posedge Config_Clock) begin
      if (Config_Reset) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         widx_q       <= '0;
         shreg_q      <= '0;
         rb_acc_q     <= '0;
         rb_word_q    <= '0;
         rb_valid_q   <= 1'b0;
         word_ready_q <= 1'b0;
         cfg_data_q   <= 1'b0;
         shift_en_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         rb_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_FETCH;
                  busy_q       <= 1'b1;
                  word_ready_q <= 1'b1;
                  bit_cnt_q    <= '0;
                  widx_q       <= '0;
                  rb_acc_q     <= '0;
               end
            end
            S_FETCH: begin
               if (word_valid) begin
                  state_q      <= S_SHIFT;
                  word_ready_q <= 1'b0;
                  shreg_q      <= word_in[31:1];
                  cfg_data_q   <= word_in[0];
                  shift_en_q   <= 1'b1;
               end
            end
            S_SHIFT: begin
               bit_cnt_q <= bit_cnt_q + CW'(1);
               widx_q    <= widx_q + 5'd1;
               shreg_q   <= shreg_q >> 1;
               if (bit_cnt_q == LAST_BIT || widx_q == 5'd31) begin
                  rb_word_q  <= rb_acc_d;
                  rb_valid_q <= 1'b1;
                  rb_acc_q   <= '0;
               end else begin
                  rb_acc_q <= rb_acc_d;
               end
               // Chain end takes priority over word boundary; leftover word bits are dropped.
               if (bit_cnt_q == LAST_BIT) begin
                  state_q    <= S_DONE;
                  shift_en_q <= 1'b0;
                  cfg_data_q <= 1'b0;
                  done_q     <= 1'b1;
               end else if (widx_q == 5'd31) begin
                  state_q      <= S_FETCH;
                  shift_en_q   <= 1'b0;
                  cfg_data_q   <= 1'b0;
                  word_ready_q <= 1'b1;
               end else begin
                  cfg_data_q <= shreg_q[0];
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign word_ready   = word_ready_q;
   assign cfg_data     = cfg_data_q;
   assign cfg_shift_en = shift_en_q;
   assign rb_word      = rb_word_q;
   assign rb_valid     = rb_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;

   if (NWORDS < 1) begin : g_bad_params
      $error("adres_config_loader: chain must hold at least one bit");
   end

endmodule

// File: tb/tb_adres_config_loader.sv
// Bench for adres_config_loader: a 184-bit chain model feeds cfg_return, scoreboards
// hold the expected serial bits and readback words.
module tb_adres_config_loader;

   localparam int CHAIN_LEN = 46;
   localparam int NUM_PE    = 4;
   localparam int TOTAL     = CHAIN_LEN * NUM_PE;
   localparam int NWORDS    = (TOTAL + 31) / 32;
   localparam int LAST_BITS = TOTAL - 32 * (NWORDS - 1);

   logic        clk = 1'b0;
   logic        Config_Reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic        cfg_data;
   logic        cfg_shift_en;
   logic        cfg_return;
   logic [31:0] rb_word;
   logic        rb_valid;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   adres_config_loader #(.CHAIN_LEN(CHAIN_LEN), .NUM_PE(NUM_PE)) dut (
      .Config_Clock (clk),
      .Config_Reset (Config_Reset),
      .start        (start),
      .word_in      (word_in),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .cfg_data     (cfg_data),
      .cfg_shift_en (cfg_shift_en),
      .cfg_return   (cfg_return),
      .rb_word      (rb_word),
      .rb_valid     (rb_valid),
      .busy         (busy),
      .done         (done)
   );

   // Chain model: bit enters at [0], ConfigOut of the last PE is [TOTAL-1].
   logic [TOTAL-1:0] chain;
   assign cfg_return = chain[TOTAL-1];
   always @(posedge clk) if (cfg_shift_en) chain <= {chain[TOTAL-2:0], cfg_data};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;
   int shift_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rb_cnt = 0;
   int start_cyc = 0;
   bit mon_en = 1'b0;
   logic        exp_bits[$];
   logic [31:0] exp_rb[$];
   logic [31:0] exp_rb_last;
   logic [31:0] words[NWORDS];
   logic        eb_m;
   logic [31:0] erb_m;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (cfg_shift_en) begin
            shift_cnt++;
            if (exp_bits.size() == 0) chk("shift_unexpected", 1, 0);
            else begin
               eb_m = exp_bits.pop_front();
               chk("cfg_data", cfg_data, eb_m);
            end
         end else begin
            chk("cfg_data_idle", cfg_data, 0);
         end
         if (rb_valid) begin
            rb_cnt++;
            if (exp_rb.size() == 0) chk("rb_unexpected", 1, 0);
            else begin
               erb_m = exp_rb.pop_front();
               chk("rb_word", rb_word, erb_m);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic do_start();
      logic [31:0] w;
      @(posedge clk); #1;
      start = 1'b1;
      start_cyc = cyc;
      shift_cnt = 0;
      done_cnt = 0;
      rb_cnt = 0;
      for (int j = 0; j < NWORDS; j++) begin
         w = '0;
         for (int i = 0; i < 32; i++)
            if (32 * j + i < TOTAL) w[i] = chain[TOTAL-1-(32*j+i)];
         exp_rb.push_back(w);
         exp_rb_last = w;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("word_ready_latency", word_ready, 1);
   endtask

   task automatic feed_word(input logic [31:0] w, input bit last, input int stall);
      int  guard;
      bit  acc;
      if (stall > 0) begin
         word_valid = 1'b0;
         guard = 0;
         while (!word_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
         end
         repeat (stall) begin
            @(posedge clk); #1;
         end
      end
      word_valid = 1'b1;
      word_in = w;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 200) begin
         acc = word_ready;
         @(posedge clk); #1;
         guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      else for (int i = 0; i < (last ? LAST_BITS : 32); i++) exp_bits.push_back(w[i]);
   endtask

   task automatic run_words(input int stall_word, input int stall);
      for (int j = 0; j < NWORDS; j++)
         feed_word(words[j], j == NWORDS - 1, j == stall_word ? stall : 0);
      word_valid = 1'b0;
   endtask

   task automatic rand_words(input bit first_five);
      for (int j = 0; j < NWORDS; j++) words[j] = $urandom;
      if (first_five) words[0] = 32'h0000_0005;
   endtask

   task automatic wait_done(input int limit);
      int g = 0;
      while (done_cnt == 0 && g < limit) begin
         @(posedge clk); #1;
         g++;
      end
      chk("done_seen", done_cnt != 0, 1);
      chk("busy_after_done", busy, 0);
   endtask

   task automatic check_load(input int exp_latency);
      logic [TOTAL-1:0] e;
      for (int k = 0; k < TOTAL; k++) e[TOTAL-1-k] = words[k/32][k%32];
      chk("shift_count", shift_cnt, TOTAL);
      chk("done_latency", done_cyc - start_cyc, exp_latency);
      chk("rb_pulses", rb_cnt, NWORDS);
      chk("rb_queue_empty", exp_rb.size(), 0);
      chk("bit_queue_empty", exp_bits.size(), 0);
      chk("chain_contents", chain, e);
      chk("rb_hold", rb_word, exp_rb_last);
   endtask

   task automatic pulse_start_at(input int offset);
      while (cyc < start_cyc + offset) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_word_ready"}, word_ready, 0);
      chk({tag, "_cfg_data"}, cfg_data, 0);
      chk({tag, "_shift_en"}, cfg_shift_en, 0);
      chk({tag, "_rb_valid"}, rb_valid, 0);
      chk({tag, "_rb_word"}, rb_word, 0);
   endtask

   initial begin
      for (int i = 0; i < TOTAL; i++) chain[i] = 1'($urandom_range(0, 1));
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      Config_Reset = 1'b0;
      mon_en = 1'b1;

      // Unstalled load, first word 5 gives serial 1,0,1,0,0...
      rand_words(1'b1);
      do_start();
      run_words(-1, 0);
      wait_done(400);
      check_load(TOTAL + NWORDS + 1);

      // 10-cycle stall before word 3 plus stray start pulses mid-load.
      rand_words(1'b0);
      do_start();
      fork
         run_words(3, 10);
         begin
            pulse_start_at(20);
            pulse_start_at(100);
         end
      join
      wait_done(400);
      check_load(TOTAL + NWORDS + 1 + 10);
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("single_done", done_cnt, 1);
      chk("idle_after_stray_start", busy, 0);

      // Reset mid-load, coincident with start and word_valid.
      rand_words(1'b0);
      do_start();
      feed_word(words[0], 1'b0, 0);
      feed_word(words[1], 1'b0, 0);
      begin
         int g = 0;
         while (shift_cnt < 50 && g < 200) begin
            @(posedge clk); #1;
            g++;
         end
      end
      chk("reached_shift_50", shift_cnt, 50);
      Config_Reset = 1'b1;
      start = 1'b1;
      word_valid = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("midload_reset");
      Config_Reset = 1'b0;
      start = 1'b0;
      word_valid = 1'b0;
      exp_bits.delete();
      exp_rb.delete();
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("idle_after_reset", busy, 0);

      // Fresh load after abort, with start coinciding with DONE.
      rand_words(1'b0);
      do_start();
      fork
         run_words(-1, 0);
         pulse_start_at(TOTAL + NWORDS + 1);
      join
      wait_done(400);
      check_load(TOTAL + NWORDS + 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("start_at_done_ignored_busy", busy, 0);
      chk("start_at_done_ignored_ready", word_ready, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adres_config_loader.md
ADRES_CONFIG_LOADER -- requirements
Module: adres_config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 46, meaning config bits per PE (4+3+3+3+1 selects + 32 const).
REQ-002 SHALL have parameter NUM_PE, default 4, meaning PEs daisy-chained on one scan chain (2x2 array).
REQ-003 SHALL derive TOTAL = CHAIN_LEN*NUM_PE (184) and NWORDS = ceil(TOTAL/32) (6).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Config_Clock  in  1  sole clock, rising edge.
REQ-006 Config_Reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse, begins a full chain load.
REQ-008 word_in  in  32  configuration word, LSB shifted first.
REQ-009 word_valid  in  1  word_in valid.
REQ-010 word_ready  out  1  loader accepts word_in this cycle.
REQ-011 cfg_data  out  1  serial bit to ConfigIn of first PE.
REQ-012 cfg_shift_en  out  1  chain shift enable; chain advances only when high.
REQ-013 cfg_return  in  1  serial bit from ConfigOut of last PE.
REQ-014 rb_word  out  32  captured previous-config readback word.
REQ-015 rb_valid  out  1  one-cycle pulse, rb_word valid.
REQ-016 busy  out  1  load in progress.
REQ-017 done  out  1  one-cycle pulse, load complete.

Function
REQ-018 SHALL implement FSM IDLE, FETCH, SHIFT, DONE.
REQ-019 IDLE: busy=0, word_ready=0; start -> FETCH, bit counter and word bit index cleared.
REQ-020 FETCH: busy=1, word_ready=1, cfg_shift_en=0; word_valid&&word_ready loads 32-bit shift register -> SHIFT; no valid -> stay FETCH (stall, chain frozen).
REQ-021 SHIFT: word_ready=0, cfg_shift_en=1, cfg_data=shreg[0]; each cycle shreg shifts right, bit counter and word bit index increment.
REQ-022 SHIFT exit: bit counter reaches TOTAL-1 -> DONE (priority); else word bit index 31 -> FETCH.
REQ-023 Last word: only TOTAL-32*(NWORDS-1) low bits (24) shifted; upper bits discarded, never driven.
REQ-024 DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
REQ-025 cfg_data SHALL be 0 and cfg_shift_en 0 in every state other than SHIFT.
REQ-026 Exactly TOTAL cycles with cfg_shift_en=1 per load, regardless of stalls.
REQ-027 start while busy SHALL be ignored; start coincident with DONE SHALL be ignored.
REQ-028 Latency: start at cycle t -> word_ready=1 at t+1; word accepted at t+1 -> first cfg_shift_en at t+2.
REQ-029 Unstalled load SHALL take TOTAL+NWORDS+1 cycles from start to done (191 at defaults).
REQ-030 Readback: during every SHIFT cycle cfg_return SHALL shift into rb shift register LSB-first (first returned bit lands in bit 0).
REQ-031 rb_valid SHALL pulse the cycle after each 32nd captured bit with rb_word holding those 32 bits.
REQ-032 Final partial readback (24 bits) SHALL be emitted with rb_valid in DONE, zero-extended in upper bits.
REQ-033 rb_word SHALL hold its value between pulses; no backpressure on readback.

Reset
REQ-034 Config_Reset SHALL force IDLE, busy=0, done=0, word_ready=0, cfg_data=0, cfg_shift_en=0, rb_valid=0, rb_word=0, counters 0.
REQ-035 Reset mid-load SHALL abort immediately; next cycle cfg_shift_en=0; partially shifted chain state is not repaired; new start required.
REQ-036 Reset SHALL take precedence over start and word_valid in the same cycle.

Verification
REQ-037 Reset, start, supply 6 words back-to-back with word_valid held -> exactly 184 cfg_shift_en cycles, done at cycle 191 after start, busy low next cycle.
REQ-038 word_in=32'h0000_0005 first -> cfg_data sequence 1,0,1,0,0... on first five shift cycles.
REQ-039 Deassert word_valid 10 cycles before word 3 -> cfg_shift_en low 10 extra cycles, shift-cycle count still 184, done at cycle 201.
REQ-040 Model chain as 184-bit shift register preloaded with pattern A, load pattern B -> chain equals B, six rb_valid pulses reconstruct A (last word upper 8 bits zero).
REQ-041 Assert Config_Reset at shift cycle 50, then start again -> all outputs reset next cycle, fresh load completes normally with 184 shift cycles.
REQ-042 Pulse start at cycles 20 and 100 of a load -> ignored, single done only.
